spi_cmd_sequencer: RTL

- Command-level controller on the FPGA side of the SPI slave byte path.
- Consumes received bytes (rx_valid/rx_byte from the SPI receive path) and decodes frames: opcode, address, length, then payload.
- Drives a simple register bus.
- For reads, feeds register data into the SPI transmit path via its write/busy handshake.
- Sole sequencer of the byte send path; frames are delimited by frame_active (synchronised, active-high slave select).

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_cmd_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI command sequencer.
// Holds the FSM state enum, the byte type and the default opcodes.
package spi_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LEN,
      S_WDATA,
      S_RFETCH,
      S_RWAIT,
      S_RSEND,
      S_SKIP
   } state_t;

   localparam byte_t WR_OP_DEF = 8'h01;
   localparam byte_t RD_OP_DEF = 8'h02;

endpackage

// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: decodes opcode/address/length frames from the
// SPI receive path, issues register writes/reads, and streams read data
// to the SPI transmit path.
// Ports:
//   clk, rst                 clock, async active-high reset
//   frame_active             synchronised slave select (high = in frame)
//   rx_valid, rx_byte        received byte strobe and data
//   tx_busy, tx_write, tx_byte  send path handshake and data
//   reg_addr, reg_wdata, reg_we, reg_re, reg_rdata, reg_rvalid  register bus
//   frame_done, frame_err    one-cycle completion / error pulses
module spi_cmd_sequencer
   import spi_pkg::*;
#(
   parameter int    ADDR_W = 8,
   parameter byte_t WR_OP  = WR_OP_DEF,
   parameter byte_t RD_OP  = RD_OP_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_active,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   input  logic              tx_busy,
   output logic              tx_write,
   output logic [7:0]        tx_byte,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [7:0]        reg_rdata,
   input  logic              reg_rvalid,
   output logic              frame_done,
   output logic              frame_err
);

   state_t            state_q, state_d;
   logic              is_rd_q, is_rd_d;
   byte_t             cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   byte_t             wdata_q, wdata_d;
   byte_t             txb_q, txb_d;
   logic              we_q, we_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              rx_ok;

   assign rx_ok = rx_valid & frame_active;

   always_comb begin
      state_d = state_q;
      is_rd_d = is_rd_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      txb_d   = txb_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      // Address advances the cycle after a write strobe so the
      // strobe itself sees the address it was issued for.
      if (we_q)
         addr_d = addr_q + ADDR_W'(1);
      if (!frame_active && state_q != S_IDLE) begin
         state_d = S_IDLE;
         err_d   = (state_q != S_SKIP);
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (rx_ok) begin
                  if (rx_byte == WR_OP || rx_byte == RD_OP) begin
                     is_rd_d = (rx_byte == RD_OP);
                     state_d = S_ADDR;
                  end else begin
                     err_d   = 1'b1;
                     state_d = S_SKIP;
                  end
               end
            end
            S_ADDR: begin
               if (rx_ok) begin
                  addr_d  = ADDR_W'(rx_byte);
                  state_d = S_LEN;
               end
            end
            S_LEN: begin
               if (rx_ok) begin
                  cnt_d = rx_byte;
                  if (rx_byte == 8'd0) begin
                     done_d  = 1'b1;
                     state_d = S_SKIP;
                  end else begin
                     state_d = is_rd_q ? S_RFETCH : S_WDATA;
                  end
               end
            end
            S_WDATA: begin
               if (rx_ok) begin
                  wdata_d = rx_byte;
                  we_d    = 1'b1;
                  cnt_d   = cnt_q - 8'd1;
                  if (cnt_q == 8'd1) begin
                     done_d  = 1'b1;
                     state_d = S_SKIP;
                  end
               end
            end
            S_RFETCH: state_d = S_RWAIT;
            S_RWAIT: begin
               if (reg_rvalid) begin
                  txb_d   = reg_rdata;
                  state_d = S_RSEND;
               end
            end
            S_RSEND: begin
               if (!tx_busy) begin
                  addr_d = addr_q + ADDR_W'(1);
                  cnt_d  = cnt_q - 8'd1;
                  if (cnt_q == 8'd1) begin
                     done_d  = 1'b1;
                     state_d = S_SKIP;
                  end else begin
                     state_d = S_RFETCH;
                  end
               end
            end
            S_SKIP: state_d = S_SKIP;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         is_rd_q <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         txb_q   <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         is_rd_q <= is_rd_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         txb_q   <= txb_d;
         we_q    <= we_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Read-side strobes follow the state directly: reg_re must sit on a
   // stable address, and tx_write must see tx_busy in its own cycle.
   assign reg_re     = (state_q == S_RFETCH) & frame_active;
   assign tx_write   = (state_q == S_RSEND) & frame_active & ~tx_busy;
   assign tx_byte    = txb_q;
   assign reg_addr   = addr_q;
   assign reg_wdata  = wdata_q;
   assign reg_we     = we_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;

endmodule
